// File: rtl/bcd_updown_counter_nd.sv
// N-digit BCD up/down counter: debounced push buttons, sync clear/load,
// wrap flags, registered seven-segment outputs.
// Optional: BCD_LZ_BLANK_EN enables leading-zero blanking on display.
// Ports:
//   src_clk, rst (async, active-low)
//   push_up, push_dn  raw async buttons, active-high
//   clr, load, load_val  sync strobes and BCD load value
//   cnt_bcd  count; display  7 segs/digit, g..a
//   carry_out, borrow_out, load_err  one-cycle flags
module bcd_updown_counter_nd #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SEG_ACTIVE_LOW  = 1
) (
  input  logic                  src_clk,
  input  logic                  rst,
  input  logic                  push_up,
  input  logic                  push_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt_bcd,
  output logic [7*DIGITS-1:0]   display,
  output logic                  carry_out,
  output logic                  borrow_out,
  output logic                  load_err
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [6:0] SEG_ZERO =
    (SEG_ACTIVE_LOW != 0) ? 7'b1000000 : 7'b0111111;
  localparam logic [6:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;

  typedef enum logic {
    STABLE,
    CHANGING
  } db_state_t;

  // index 0 = up button, index 1 = down button
  logic [1:0]  raw;
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  db_state_t   state    [2];
  db_state_t   state_nx [2];
  logic [CW-1:0] dcnt    [2];
  logic [CW-1:0] dcnt_nx [2];
  logic [1:0]  lvl;
  logic [1:0]  lvl_nx;
  logic [1:0]  lvl_q;
  logic [1:0]  rise;
  logic        up_req;
  logic        dn_req;

  assign raw = {push_dn, push_up};

  always_ff @(posedge src_clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state[i] <= STABLE;
        dcnt[i]  <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl   <= lvl_nx;
      lvl_q <= lvl;
      for (int i = 0; i < 2; i++) begin
        state[i] <= state_nx[i];
        dcnt[i]  <= dcnt_nx[i];
      end
    end
  end

  // The entry cycle into CHANGING already counts as one mismatch
  // cycle, so the level flips after exactly DEBOUNCE_CYCLES cycles.
  always_comb begin
    lvl_nx = lvl;
    for (int i = 0; i < 2; i++) begin
      state_nx[i] = state[i];
      dcnt_nx[i]  = '0;
      unique case (state[i])
        STABLE: begin
          if (sync2[i] != lvl[i]) begin
            state_nx[i] = CHANGING;
            dcnt_nx[i]  = CW'(1);
          end
        end
        CHANGING: begin
          if (sync2[i] == lvl[i]) begin
            state_nx[i] = STABLE;
          end else if (dcnt[i] == CMAX) begin
            state_nx[i] = STABLE;
            lvl_nx[i]   = sync2[i];
          end else begin
            dcnt_nx[i] = dcnt[i] + CW'(1);
          end
        end
        default: state_nx[i] = STABLE;
      endcase
    end
  end

  assign rise   = lvl & ~lvl_q;
  assign up_req = rise[0];
  assign dn_req = rise[1];

  // Returns {carry, value}
  function automatic logic [4*DIGITS:0] bcd_inc(
    input logic [4*DIGITS-1:0] v
  );
    logic [4*DIGITS-1:0] r;
    logic [3:0] d;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d = d + 4'd1;
          c = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return {c, r};
  endfunction

  // Returns {borrow, value}
  function automatic logic [4*DIGITS:0] bcd_dec(
    input logic [4*DIGITS-1:0] v
  );
    logic [4*DIGITS-1:0] r;
    logic [3:0] d;
    logic b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (b) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d = d - 4'd1;
          b = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return {b, r};
  endfunction

  logic [4*DIGITS-1:0] cnt_nx;
  logic car_nx;
  logic bor_nx;
  logic err_nx;

  always_comb begin
    cnt_nx = cnt_bcd;
    car_nx = 1'b0;
    bor_nx = 1'b0;
    err_nx = 1'b0;
    if (clr) begin
      cnt_nx = '0;
    end else if (load) begin
      cnt_nx = '0;
      for (int i = 0; i < DIGITS; i++) begin
        if (load_val[4*i +: 4] > 4'd9) begin
          err_nx = 1'b1;
        end else begin
          cnt_nx[4*i +: 4] = load_val[4*i +: 4];
        end
      end
    end else if (up_req && !dn_req) begin
      {car_nx, cnt_nx} = bcd_inc(cnt_bcd);
    end else if (dn_req && !up_req) begin
      {bor_nx, cnt_nx} = bcd_dec(cnt_bcd);
    end
  end

  always_ff @(posedge src_clk or negedge rst) begin
    if (!rst) begin
      cnt_bcd    <= '0;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      cnt_bcd    <= cnt_nx;
      carry_out  <= car_nx;
      borrow_out <= bor_nx;
      load_err   <= err_nx;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [7*DIGITS-1:0] disp_nx;

`ifdef BCD_LZ_BLANK_EN
  // zero_above[i]: digit i and every higher digit are zero
  logic [DIGITS:0] zero_above;
`endif

  always_comb begin
    disp_nx = '0;
`ifdef BCD_LZ_BLANK_EN
    zero_above = '0;
    zero_above[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] &&
                      (cnt_bcd[4*i +: 4] == 4'd0);
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (SEG_ACTIVE_LOW != 0) begin
        disp_nx[7*i +: 7] = ~seg7(cnt_bcd[4*i +: 4]);
      end else begin
        disp_nx[7*i +: 7] = seg7(cnt_bcd[4*i +: 4]);
      end
`ifdef BCD_LZ_BLANK_EN
      if (i > 0 && zero_above[i]) begin
        disp_nx[7*i +: 7] = SEG_OFF;
      end
`endif
    end
  end

  always_ff @(posedge src_clk or negedge rst) begin
    if (!rst) begin
      display <= {DIGITS{SEG_ZERO}};
    end else begin
      display <= disp_nx;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_nd.sv
// Testbench for bcd_updown_counter_nd (DIGITS=4, DEBOUNCE_CYCLES=4,
// active-low segments); expected results queued then compared.
module tb_bcd_updown_counter_nd;

  logic        src_clk;
  logic        rst;
  logic        push_up;
  logic        push_dn;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] cnt_bcd;
  logic [27:0] display;
  logic        carry_out;
  logic        borrow_out;
  logic        load_err;

  bcd_updown_counter_nd #(
    .DIGITS(4),
    .DEBOUNCE_CYCLES(4),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .src_clk(src_clk),
    .rst(rst),
    .push_up(push_up),
    .push_dn(push_dn),
    .clr(clr),
    .load(load),
    .load_val(load_val),
    .cnt_bcd(cnt_bcd),
    .display(display),
    .carry_out(carry_out),
    .borrow_out(borrow_out),
    .load_err(load_err)
  );

  typedef struct packed {
    logic        err;
    logic        bor;
    logic        car;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef BCD_LZ_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'b1111111;
`else
  localparam logic [6:0] HI_ZERO = 7'b1000000;
`endif

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge src_clk);
    #1;
  endtask

  function automatic exp_t obs();
    exp_t o;
    o = {load_err, borrow_out, carry_out, cnt_bcd};
    return o;
  endfunction

  task automatic test_reset;
    n_vec++;
    if (obs() !== exp_t'(0)) begin
      n_err++;
      $display("FAIL reset_state got %h want %h", obs(), exp_t'(0));
    end
    n_vec++;
    if (display !== {4{7'b1000000}}) begin
      n_err++;
      $display("FAIL reset_display got %b want %b",
               display, {4{7'b1000000}});
    end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_press;
    exp_t e;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0001});
    push_up = 1'b1;
    tick(6);
    n_vec++;
    if (cnt_bcd !== 16'h0000) begin
      n_err++;
      $display("FAIL press_early got %h want 0000", cnt_bcd);
    end
    tick(1);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL press_count got %h want %h", obs(), e);
    end
    tick(1);
    n_vec++;
    if (display[6:0] !== 7'b1111001) begin
      n_err++;
      $display("FAIL press_display got %b want 1111001", display[6:0]);
    end
    push_up = 1'b0;
    tick(8);
  endtask

  task automatic test_bounce;
    exp_t e;
    for (int k = 0; k < 10; k++) begin
      push_up = (k % 2 == 0);
      tick(2);
    end
    n_vec++;
    if (cnt_bcd !== 16'h0001) begin
      n_err++;
      $display("FAIL bounce_hold got %h want 0001", cnt_bcd);
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0002});
    push_up = 1'b1;
    tick(10);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL bounce_step got %h want %h", obs(), e);
    end
    push_up = 1'b0;
    tick(8);
    n_vec++;
    if (cnt_bcd !== 16'h0002) begin
      n_err++;
      $display("FAIL bounce_release got %h want 0002", cnt_bcd);
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h9999});
    load_val = 16'h9999;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL wrap_load got %h want %h", obs(), e);
    end
    exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h0000});
    push_up = 1'b1;
    tick(7);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL wrap_up got %h want %h", obs(), e);
    end
    tick(1);
    n_vec++;
    if (carry_out !== 1'b0) begin
      n_err++;
      $display("FAIL carry_pulse got %b want 0", carry_out);
    end
    push_up = 1'b0;
    tick(8);
    exp_q.push_back({1'b0, 1'b1, 1'b0, 16'h9999});
    push_dn = 1'b1;
    tick(7);
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL wrap_dn got %h want %h", obs(), e);
    end
    tick(1);
    n_vec++;
    if (borrow_out !== 1'b0) begin
      n_err++;
      $display("FAIL borrow_pulse got %b want 0", borrow_out);
    end
    push_dn = 1'b0;
    tick(8);
  endtask

  task automatic test_load_err;
    exp_t e;
    exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h1204});
    load_val = 16'h12A4;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL load_err got %h want %h", obs(), e);
    end
    tick(1);
    n_vec++;
    if (load_err !== 1'b0) begin
      n_err++;
      $display("FAIL load_err_pulse got %b want 0", load_err);
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0000});
    load_val = 16'h5A55;
    clr = 1'b1;
    load = 1'b1;
    tick(1);
    clr = 1'b0;
    load = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL clr_over_load got %h want %h", obs(), e);
    end
  endtask

  task automatic test_cancel_ripple;
    exp_t e;
    logic [15:0] lv [3] = '{16'h0050, 16'h0109, 16'h1000};
    logic [15:0] rv [3] = '{16'h0050, 16'h0110, 16'h0999};
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, lv[k]});
      load_val = lv[k];
      load = 1'b1;
      tick(1);
      load = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL ripple_load%0d got %h want %h", k, obs(), e);
      end
      exp_q.push_back({1'b0, 1'b0, 1'b0, rv[k]});
      push_up = (k != 2);
      push_dn = (k != 1);
      tick(8);
      e = exp_q.pop_front();
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL ripple_step%0d got %h want %h", k, obs(), e);
      end
      push_up = 1'b0;
      push_dn = 1'b0;
      tick(8);
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0000});
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL clear got %h want %h", obs(), e);
    end
  endtask

  task automatic test_display;
    exp_t e;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0007});
    load_val = 16'h0007;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL disp_load got %h want %h", obs(), e);
    end
    tick(1);
    n_vec++;
    if (display[6:0] !== 7'b1111000) begin
      n_err++;
      $display("FAIL disp_d0 got %b want 1111000", display[6:0]);
    end
    for (int i = 1; i < 4; i++) begin
      n_vec++;
      if (display[7*i +: 7] !== HI_ZERO) begin
        n_err++;
        $display("FAIL disp_d%0d got %b want %b",
                 i, display[7*i +: 7], HI_ZERO);
      end
    end
  endtask

  task automatic test_reset_mid;
    push_up = 1'b1;
    tick(4);
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs() !== exp_t'(0)) begin
      n_err++;
      $display("FAIL midrst_state got %h want 0", obs());
    end
    push_up = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(12);
    n_vec++;
    if (obs() !== exp_t'(0)) begin
      n_err++;
      $display("FAIL midrst_after got %h want 0", obs());
    end
  endtask

  initial begin
    rst = 1'b0;
    push_up = 1'b0;
    push_dn = 1'b0;
    clr = 1'b0;
    load = 1'b0;
    load_val = '0;
    tick(2);
    test_reset;
    test_press;
    test_bounce;
    test_wrap;
    test_load_err;
    test_cancel_ripple;
    test_display;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
